// File: rtl/whack_pkg.sv
// Shared types and defaults for the whack-a-mole player-input path.
// Holds the mole state encoding and the build-time default sizes.
package whack_pkg;

  localparam int DEF_NUM_MOLES       = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int IDX_W               = 3;

  typedef enum logic [1:0] {
    MOLE_IDLE    = 2'd0,
    MOLE_ARMED   = 2'd1,
    MOLE_WHACKED = 2'd2
  } mole_state_e;

endpackage

// File: rtl/switch_debouncer.sv
// One slide switch: two-flop synchroniser and stability-count debounce.
// The clean level only moves after DEBOUNCE_CYCLES agreeing samples.
module switch_debouncer
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_i,
  output logic clean_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q;
  logic             sync1_q;
  logic             clean_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise, then count agreeing samples; any bounce restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= switch_i;
      sync1_q <= sync0_q;
      if (sync1_q == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        clean_q <= sync1_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/whack_hit_detector.sv
// Switch conditioning, toggle events, arbitration and hit/miss judging.
// Define WHACK_MISS_PENALTY_EN to enable miss_pulse on unlit-mole toggles.
module whack_hit_detector
  import whack_pkg::*;
#(
  parameter int NUM_MOLES       = DEF_NUM_MOLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_MOLES-1:0] switch_in,
  input  logic [NUM_MOLES-1:0] mole_mask,
  input  logic                 game_active,
  output logic [NUM_MOLES-1:0] switch_clean,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [IDX_W-1:0]     hit_index
);

  logic [NUM_MOLES-1:0] clean;
  logic [NUM_MOLES-1:0] clean_prev_q;
  logic [NUM_MOLES-1:0] pending_q;
  logic [NUM_MOLES-1:0] pending_d;
  logic [NUM_MOLES-1:0] event_w;
  logic [NUM_MOLES-1:0] grant;
  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic                 hit_q;
  logic                 hit_d;
  logic                 miss_q;
  logic                 miss_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  mole_state_e          state_q [NUM_MOLES];
  mole_state_e          state_d [NUM_MOLES];

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_deb
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .switch_i(switch_in[g]),
      .clean_o (clean[g])
    );
  end

  assign event_w = clean ^ clean_prev_q;

  // Lowest-index pending toggle wins; one judgement per cycle.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_MOLES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Judge the granted toggle against the registered mole state.
  always_comb begin
    hit_d  = 1'b0;
    miss_d = 1'b0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      if (grant[i] && game_active) begin
        hit_d  = (state_q[i] == MOLE_ARMED);
`ifdef WHACK_MISS_PENALTY_EN
        miss_d = (state_q[i] == MOLE_IDLE);
`endif
      end
    end
    idx_d = (hit_d || miss_d) ? grant_idx : idx_q;
  end

  // Pending set: retire the grant, merge new toggles, flush when idle.
  always_comb begin
    pending_d = '0;
    if (game_active && grant_vld) begin
      pending_d = (pending_q & ~grant) | event_w;
    end else if (game_active) begin
      pending_d = pending_q | event_w;
    end
  end

  // Mole lifecycle: a lighting can be scored once; mask fall wins.
  always_comb begin
    for (int i = 0; i < NUM_MOLES; i++) begin
      state_d[i] = state_q[i];
      if (!mole_mask[i]) begin
        state_d[i] = MOLE_IDLE;
      end else if (state_q[i] == MOLE_IDLE) begin
        state_d[i] = MOLE_ARMED;
      end else if (grant[i] && hit_d) begin
        state_d[i] = MOLE_WHACKED;
      end
    end
  end

  // State and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clean_prev_q <= '0;
      pending_q    <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      idx_q        <= '0;
      for (int i = 0; i < NUM_MOLES; i++) begin
        state_q[i] <= MOLE_IDLE;
      end
    end else begin
      clean_prev_q <= clean;
      pending_q    <= pending_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      idx_q        <= idx_d;
      for (int i = 0; i < NUM_MOLES; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign switch_clean = clean;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign hit_index    = idx_q;

endmodule

// File: tb/tb_whack_hit_detector.sv
// Bench for whack_hit_detector with DEBOUNCE_CYCLES=4.
// Sample-window model plus directed latency and ordering checks.
module tb_whack_hit_detector;

  localparam int N = 5;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] switch_in;
  logic [N-1:0] mole_mask;
  logic         game_active;
  logic [N-1:0] switch_clean;
  logic         hit_pulse;
  logic         miss_pulse;
  logic [2:0]   hit_index;

  int checks = 0;
  int failures = 0;

  whack_hit_detector #(
    .NUM_MOLES      (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .switch_in   (switch_in),
    .mole_mask   (mole_mask),
    .game_active (game_active),
    .switch_clean(switch_clean),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .hit_index   (hit_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] = raw switch sample taken k edges ago (0 = this edge).
  logic [N-1:0] hist [0:D+1];
  logic [N-1:0] m_clean;
  logic [N-1:0] m_toggled;
  logic [N-1:0] m_pending;
  bit           m_armed   [N];
  bit           m_whacked [N];
  logic         m_hit;
  logic         m_miss;
  logic [2:0]   m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D + 1; k++) hist[k] = '0;
      m_clean   = '0;
      m_toggled = '0;
      m_pending = '0;
      m_hit     = 1'b0;
      m_miss    = 1'b0;
      m_idx     = '0;
      for (int i = 0; i < N; i++) begin
        m_armed[i]   = 1'b0;
        m_whacked[i] = 1'b0;
      end
    end else begin
      int j;
      bit stable;
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = switch_in;
      m_hit  = 1'b0;
      m_miss = 1'b0;
      j = -1;
      if (game_active) begin
        for (int i = N - 1; i >= 0; i--)
          if (m_pending[i]) j = i;
      end
      if (j >= 0) begin
        m_pending[j] = 1'b0;
        if (m_armed[j]) begin
          m_hit = 1'b1;
          m_idx = 3'(j);
        end else if (!m_whacked[j]) begin
`ifdef WHACK_MISS_PENALTY_EN
          m_miss = 1'b1;
          m_idx  = 3'(j);
`endif
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!mole_mask[i]) begin
          m_armed[i]   = 1'b0;
          m_whacked[i] = 1'b0;
        end else if (!m_armed[i] && !m_whacked[i]) begin
          m_armed[i] = 1'b1;
        end else if (m_hit && j == i) begin
          m_armed[i]   = 1'b0;
          m_whacked[i] = 1'b1;
        end
      end
      m_pending = game_active ? (m_pending | m_toggled) : '0;
      m_toggled = '0;
      for (int i = 0; i < N; i++) begin
        stable = 1'b1;
        for (int k = 3; k <= D + 1; k++)
          if (hist[k][i] != hist[2][i]) stable = 1'b0;
        if (stable && hist[2][i] != m_clean[i]) begin
          m_clean[i]   = hist[2][i];
          m_toggled[i] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_clean", switch_clean, m_clean);
    chk("cyc_hit", hit_pulse, m_hit);
    chk("cyc_miss", miss_pulse, m_miss);
    chk("cyc_idx", hit_index, m_idx);
  end

  // ---------------- directed stimulus ----------------
  // Called just after driving at a negedge; n counts edges from edge k.
  task automatic wait_pulse(input bit want_miss, output int n);
    n = 99;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if ((want_miss ? miss_pulse : hit_pulse) === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cyc, output int cnt);
    cnt = 0;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
      if (hit_pulse === 1'b1 || miss_pulse === 1'b1) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int clean_n;
    int hit_n;
    rst_n       = 1'b0;
    switch_in   = '0;
    mole_mask   = '0;
    game_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clean", switch_clean, 0);
    chk("rst_hit", hit_pulse, 0);
    chk("rst_miss", miss_pulse, 0);
    chk("rst_idx", hit_index, 0);
    rst_n = 1'b1;
    @(negedge clk);
    game_active = 1'b1;
    mole_mask   = 5'b00100;
    repeat (2) @(negedge clk);

    // Basic hit on lit mole 2.
    switch_in[2] = 1'b1;
    wait_pulse(1'b0, n);
    chk("hit_latency", n, D + 3);
    chk("hit_idx2", hit_index, 2);
    @(posedge clk);
    #1;
    chk("hit_one_cycle", hit_pulse, 0);

    // Second toggle on a whacked mole is ignored.
    @(negedge clk);
    switch_in[2] = 1'b0;
    count_pulses(15, cnt);
    chk("whacked_silent", cnt, 0);
    @(negedge clk);
    mole_mask = 5'b00000;
    repeat (2) @(negedge clk);
    mole_mask = 5'b00100;
    repeat (2) @(negedge clk);
    switch_in[2] = 1'b1;
    wait_pulse(1'b0, n);
    chk("rearm_latency", n, D + 3);
    chk("rearm_idx", hit_index, 2);

    // Toggle on an unlit mole.
    @(negedge clk);
    mole_mask = 5'b00001;
    repeat (2) @(negedge clk);
    switch_in[3] = 1'b1;
`ifdef WHACK_MISS_PENALTY_EN
    wait_pulse(1'b1, n);
    chk("miss_latency", n, D + 3);
    chk("miss_idx", hit_index, 3);
    @(posedge clk);
    #1;
    chk("miss_one_cycle", miss_pulse, 0);
`else
    count_pulses(15, cnt);
    chk("miss_dropped", cnt, 0);
    chk("miss_idx_held", hit_index, 2);
`endif

    // Bouncing switch 1 gives a single event.
    @(negedge clk);
    mole_mask = 5'b00010;
    repeat (2) @(negedge clk);
    switch_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    switch_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    switch_in[1] = 1'b1;
    clean_n = 99;
    hit_n   = 99;
    cnt     = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (switch_clean[1] && clean_n == 99) clean_n = c;
      if (hit_pulse) begin
        cnt++;
        if (hit_n == 99) hit_n = c;
      end
    end
    chk("bounce_clean_at", clean_n, D + 1);
    chk("bounce_hit_at", hit_n, D + 3);
    chk("bounce_hits", cnt, 1);

    // Simultaneous toggles on 0 and 4.
    @(negedge clk);
    mole_mask = 5'b10001;
    repeat (2) @(negedge clk);
    switch_in[0] = 1'b1;
    switch_in[4] = 1'b1;
    wait_pulse(1'b0, n);
    chk("pair_latency", n, D + 3);
    chk("pair_idx0", hit_index, 0);
    @(posedge clk);
    #1;
    chk("pair_hit2", hit_pulse, 1);
    chk("pair_idx4", hit_index, 4);
    @(posedge clk);
    #1;
    chk("pair_done", hit_pulse, 0);

    // Reset in the middle of a debounce.
    @(negedge clk);
    switch_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_clean", switch_clean, 0);
    chk("midrst_hit", hit_pulse, 0);
    chk("midrst_miss", miss_pulse, 0);
    chk("midrst_idx", hit_index, 0);
    game_active = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    switch_in[0] = 1'b1;
    count_pulses(20, cnt);
    chk("inactive_silent", cnt, 0);
    chk("inactive_clean", switch_clean, 5'b11111);
    @(negedge clk);
    game_active = 1'b1;
    count_pulses(10, cnt);
    chk("flushed_pending", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
